// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
package ps2_pkg;

   typedef enum logic [1:0] {StIdle, StData, StParity, StStop} frame_state_e;

   localparam logic [7:0] CodeE0 = 8'hE0;
   localparam logic [7:0] CodeF0 = 8'hF0;
   localparam logic [7:0] CodeE1 = 8'hE1;

   // Bytes dropped silently when no prefix is pending (BAT, ack, resend, echo, errors).
   localparam int unsigned NumSilent = 6;
   localparam logic [NumSilent*8-1:0] SilentCodes = {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

   localparam int unsigned KeyToggle  = 10;
   localparam int unsigned KeyPressed = 9;
   localparam int unsigned KeyExt     = 8;

   localparam logic [2:0] SkipLen = 3'd7;

   function automatic logic is_silent(input logic [7:0] code);
      logic hit;
      hit = 1'b0;
      for (int unsigned i = 0; i < NumSilent; i++) begin
         if (code == SilentCodes[i*8 +: 8]) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// PS/2 pin inputs and the ps2_key event word produced from them.
interface ps2_key_decoder_if;
   logic        ps2_clk_in;
   logic        ps2_data_in;
   logic [10:0] ps2_key;
   logic        key_strobe;
   logic        frame_err;

   modport master (
      input  ps2_clk_in,
      input  ps2_data_in,
      output ps2_key,
      output key_strobe,
      output frame_err
   );

   modport slave (
      output ps2_clk_in,
      output ps2_data_in,
      input  ps2_key,
      input  key_strobe,
      input  frame_err
   );
endinterface

// File: rtl/ps2_line_filter.sv
// Synchronises the PS/2 lines and debounces the clock; emits a pulse on each clean falling edge.
module ps2_line_filter #(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic ps2_clk_in,
   input  logic ps2_data_in,
   output logic fall,
   output logic data
);

   localparam int unsigned CntW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

   logic [1:0]      clk_sync;
   logic [1:0]      data_sync;
   logic            level;
   logic [CntW-1:0] cnt;
   logic            flip;

   assign flip = (clk_sync[1] != level) && (cnt == CntW'(FILTER_LEN - 1));
   assign fall = flip && level;
   assign data = data_sync[1];

   // Sync flops reset high so the idle bus does not look like an edge after reset.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         level     <= 1'b1;
         cnt       <= '0;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk_in};
         data_sync <= {data_sync[0], ps2_data_in};
         if (clk_sync[1] == level) begin
            cnt <= '0;
         end else if (flip) begin
            level <= clk_sync[1];
            cnt   <= '0;
         end else begin
            cnt <= cnt + CntW'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 frame receiver and set-2 prefix stripper producing toggle-flagged key events.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 43000
) (
   input logic                 clk_sys,
   input logic                 reset_n,
   ps2_key_decoder_if.master   bus
);

   localparam int unsigned TimW = $clog2(TIMEOUT_CYCLES + 1);

   logic            fall;
   logic            data;
   frame_state_e    state;
   logic [2:0]      bitcnt;
   logic [7:0]      shift;
   logic            parity_bit;
   logic [TimW-1:0] to_cnt;
   logic            ext;
   logic            rel;
   logic [2:0]      skip;
   logic [10:0]     key_q;
   logic            strobe_q;
   logic            err_q;
   logic            timed_out;

   ps2_line_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_filter (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .ps2_clk_in  (bus.ps2_clk_in),
      .ps2_data_in (bus.ps2_data_in),
      .fall        (fall),
      .data        (data)
   );

   assign timed_out = (state != StIdle) && (to_cnt == TimW'(TIMEOUT_CYCLES));

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= StIdle;
         bitcnt     <= '0;
         shift      <= '0;
         parity_bit <= 1'b0;
         to_cnt     <= '0;
         ext        <= 1'b0;
         rel        <= 1'b0;
         skip       <= '0;
         key_q      <= '0;
         strobe_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         err_q    <= 1'b0;

         if (fall) begin
            to_cnt <= '0;
         end else if (to_cnt != TimW'(TIMEOUT_CYCLES)) begin
            to_cnt <= to_cnt + TimW'(1);
         end

         // A stalled frame wins over a coincident sample point.
         if (timed_out) begin
            state <= StIdle;
            err_q <= 1'b1;
            ext   <= 1'b0;
            rel   <= 1'b0;
         end else if (fall) begin
            unique case (state)
               StIdle: begin
                  if (!data) begin
                     state  <= StData;
                     bitcnt <= '0;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               StData: begin
                  shift  <= {data, shift[7:1]};
                  bitcnt <= bitcnt + 3'd1;
                  if (bitcnt == 3'd7) state <= StParity;
               end
               StParity: begin
                  parity_bit <= data;
                  state      <= StStop;
               end
               StStop: begin
                  state <= StIdle;
                  if (data && (^{shift, parity_bit})) begin
                     if (skip != 3'd0) begin
                        skip <= skip - 3'd1;
                        if (skip == 3'd1) begin
                           ext <= 1'b0;
                           rel <= 1'b0;
                        end
                     end else if (shift == CodeE1) begin
                        skip <= SkipLen;
                     end else if (shift == CodeE0) begin
                        ext <= 1'b1;
                     end else if (shift == CodeF0) begin
                        rel <= 1'b1;
                     end else if (!(is_silent(shift) && !ext && !rel)) begin
                        key_q[KeyToggle]  <= ~key_q[KeyToggle];
                        key_q[KeyPressed] <= ~rel;
                        key_q[KeyExt]     <= ext;
                        key_q[7:0]        <= shift;
                        strobe_q          <= 1'b1;
                        ext               <= 1'b0;
                        rel               <= 1'b0;
                     end
                  end else begin
                     err_q <= 1'b1;
                     ext   <= 1'b0;
                     rel   <= 1'b0;
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

   assign bus.ps2_key    = key_q;
   assign bus.key_strobe = strobe_q;
   assign bus.frame_err  = err_q;

endmodule
